// File: rtl/r5p_hpm.sv
// R5P hardware performance monitor: CNT event counters with per-counter event masks and inhibits.
// Optional overflow flags and interrupt are enabled with `define R5P_HPM_OVF_EN.
module r5p_hpm #(
  parameter int unsigned CNT = 4,
  parameter int unsigned CW  = 64,
  parameter int unsigned EW  = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [EW-1:0] evt,
  input  logic          csr_ren,
  input  logic          csr_wen,
  input  logic [11:0]   csr_adr,
  input  logic [31:0]   csr_wdt,
  output logic [31:0]   csr_rdt,
  output logic          csr_hit,
  output logic          irq
);

  localparam int unsigned HW = CW - 32;
  // evt bit 1 is reserved and must never count, whatever the mask says.
  localparam logic [EW-1:0] EVT_VALID = ~EW'(2);

  logic [CW-1:0]  cnt_q  [CNT];
  logic [CW-1:0]  cnt_d  [CNT];
  logic [EW-1:0]  mask_q [CNT];
  logic [EW-1:0]  mask_d [CNT];
  logic [CNT-1:0] inh_q, inh_d;
  logic [CNT-1:0] inc;
  logic [31:0]    rdt_q, rdt_d;
  logic           hit_q, hit_d;
`ifdef R5P_HPM_OVF_EN
  logic [CNT-1:0] of_q, of_d;
  logic [CNT-1:0] ofen_q, ofen_d;
  logic           irq_q, irq_d;
`endif

  logic unused_wdt;
  assign unused_wdt = ^csr_wdt;

  always_comb begin
    inc = '0;
    for (int n = 0; n < CNT; n++) begin
      inc[n] = !inh_q[n] && (|(evt & mask_q[n] & EVT_VALID));
    end
  end

  always_comb begin
    inh_d = inh_q;
    rdt_d = rdt_q;
    hit_d = hit_q;
`ifdef R5P_HPM_OVF_EN
    of_d   = of_q;
    ofen_d = ofen_q;
    irq_d  = |(of_q & ofen_q);
`endif
    if (csr_ren) begin
      rdt_d = '0;
      hit_d = 1'b0;
    end
    if (csr_wen && csr_adr == 12'h320) inh_d = csr_wdt[3 +: CNT];
    if (csr_ren && csr_adr == 12'h320) begin
      rdt_d = 32'(inh_q) << 3;
      hit_d = 1'b1;
    end
    for (int n = 0; n < CNT; n++) begin
      cnt_d[n]  = cnt_q[n];
      mask_d[n] = mask_q[n];
      if (inc[n]) cnt_d[n] = cnt_q[n] + CW'(1);
`ifdef R5P_HPM_OVF_EN
      if (inc[n] && (&cnt_q[n])) of_d[n] = 1'b1;
`endif
      // Writes are applied after the increment so they override it.
      if (csr_wen && csr_adr == 12'h323 + 12'(n)) begin
        mask_d[n] = csr_wdt[EW-1:0];
`ifdef R5P_HPM_OVF_EN
        of_d[n]   = csr_wdt[31];
        ofen_d[n] = csr_wdt[30];
`endif
      end
      if (csr_wen && csr_adr == 12'hB03 + 12'(n)) cnt_d[n] = {cnt_q[n][CW-1:32], csr_wdt};
      if (csr_wen && csr_adr == 12'hB83 + 12'(n)) cnt_d[n] = {csr_wdt[HW-1:0], cnt_q[n][31:0]};
      if (csr_ren && csr_adr == 12'h323 + 12'(n)) begin
`ifdef R5P_HPM_OVF_EN
        rdt_d = {of_q[n], ofen_q[n], 30'(mask_q[n])};
`else
        rdt_d = 32'(mask_q[n]);
`endif
        hit_d = 1'b1;
      end
      if (csr_ren && csr_adr == 12'hB03 + 12'(n)) begin
        rdt_d = cnt_q[n][31:0];
        hit_d = 1'b1;
      end
      if (csr_ren && csr_adr == 12'hB83 + 12'(n)) begin
        rdt_d = 32'(cnt_q[n][CW-1:32]);
        hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < CNT; n++) begin
        cnt_q[n]  <= '0;
        mask_q[n] <= '0;
      end
      inh_q <= '0;
      rdt_q <= '0;
      hit_q <= 1'b0;
`ifdef R5P_HPM_OVF_EN
      of_q   <= '0;
      ofen_q <= '0;
      irq_q  <= 1'b0;
`endif
    end else begin
      for (int n = 0; n < CNT; n++) begin
        cnt_q[n]  <= cnt_d[n];
        mask_q[n] <= mask_d[n];
      end
      inh_q <= inh_d;
      rdt_q <= rdt_d;
      hit_q <= hit_d;
`ifdef R5P_HPM_OVF_EN
      of_q   <= of_d;
      ofen_q <= ofen_d;
      irq_q  <= irq_d;
`endif
    end
  end

  assign csr_rdt = rdt_q;
  assign csr_hit = hit_q;
`ifdef R5P_HPM_OVF_EN
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
